// File: rtl/jtpopeye_pkg.sv
// Shared constants and pixel/video word layouts for the Popeye scan doubler.
package jtpopeye_pkg;

    localparam int AW      = 9;   // line-buffer address width
    localparam int HSW_MIN = 4;   // narrowest doubled HS pulse, in pxl2_cen ticks

    // Word stored in the line buffer: {HB, B[1:0], G[2:0], R[2:0]}
    typedef struct packed {
        logic       hb;
        logic [1:0] b;
        logic [2:0] g;
        logic [2:0] r;
    } pxl_t;

    // Full video bundle as it appears on the output ports
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
    } vid_t;

    // Blanked, no-sync state shown until a complete line is available
    localparam vid_t VID_IDLE = '{r: 3'd0, g: 3'd0, b: 2'd0,
                                  hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/jtpopeye_linebuf.sv
// Two-bank line store: one write port at pixel rate, one registered read
// port at double pixel rate. Bank is the address MSB.
module jtpopeye_linebuf
    import jtpopeye_pkg::pxl_t;
#(
    parameter int AW = jtpopeye_pkg::AW
)(
    input  logic          clk,
    input  logic          wr_cen,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  pxl_t          wr_data,
    input  logic          rd_cen,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output pxl_t          rd_data
);

    pxl_t mem [0:(2**(AW+1))-1];
    pxl_t rd_d, rd_q;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_cen) mem[{wr_bank, wr_addr}] <= wr_data;
    end

    // Read register keeps its value between pxl2_cen ticks; a same-tick
    // write to the read location returns the old contents
    always_comb begin
        rd_d = rd_q;
        if (rd_cen) rd_d = mem[{rd_bank, rd_addr}];
    end

    // Read data register
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/jtpopeye_scandbl.sv
// Scan doubler: stores each native line and replays it twice at pxl2 rate,
// or passes the native video through registered when doubling is off.
module jtpopeye_scandbl
    import jtpopeye_pkg::pxl_t, jtpopeye_pkg::vid_t, jtpopeye_pkg::VID_IDLE;
#(
    parameter int AW      = jtpopeye_pkg::AW,
    parameter int HSW_MIN = jtpopeye_pkg::HSW_MIN
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       pxl2_cen,
    input  logic       en,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [1:0] blue,
    input  logic       HB,
    input  logic       VB,
    input  logic       HS,
    input  logic       VS,
    output logic [2:0] dbl_red,
    output logic [2:0] dbl_green,
    output logic [1:0] dbl_blue,
    output logic       dbl_HB,
    output logic       dbl_VB,
    output logic       dbl_HS,
    output logic       dbl_VS
);

    localparam logic [AW-1:0] ADDR_MAX  = '1;
    localparam logic [7:0]    HSW_FLOOR = 8'(HSW_MIN);

    // write side / line bookkeeping
    logic          hs_last_d, hs_last_q;
    logic          synced_d, synced_q;     // an HS edge has been seen since reset
    logic          bank_d, bank_q;
    logic          en_lat_d, en_lat_q;
    logic [AW-1:0] wr_addr_d, wr_addr_q;
    logic [AW-1:0] line_len_d, line_len_q;
    logic [7:0]    hsw_d, hsw_q;           // running HS pulse width
    logic [7:0]    hsw_line_d, hsw_line_q; // width of the pulse of the buffered line
    logic          vb_line_d, vb_line_q;
    logic          vs_line_d, vs_line_q;
    vid_t          byp_d, byp_q;

    // read side, two-stage output pipeline
    logic [AW-1:0] rd_addr_d, rd_addr_q;
    logic          val1_d, val1_q, val2_d, val2_q;
    logic          hs1_d, hs1_q, hs2_d, hs2_q;
    logic          vb1_d, vb1_q, vb2_d, vb2_q;
    logic          vs1_d, vs1_q, vs2_d, vs2_q;
    pxl_t          pix2_d, pix2_q;

    logic          hs_edge;
    logic          wr_bank;
    logic [AW-1:0] wr_sel;
    pxl_t          cur_pxl, rd_pxl;
    logic [7:0]    hsw_eff;
    vid_t          out_vid;

    jtpopeye_linebuf #(.AW(AW)) u_lb (
        .clk     (clk),
        .wr_cen  (pxl_cen),
        .wr_bank (wr_bank),
        .wr_addr (wr_sel),
        .wr_data (cur_pxl),
        .rd_cen  (pxl2_cen),
        .rd_bank (~bank_q),
        .rd_addr (rd_addr_q),
        .rd_data (rd_pxl)
    );

    // Write side: edge detect, address counter, per-line captures.
    // The HS-edge pixel is pixel 0 of the new line, so it lands at address 0
    // of the freshly selected bank and line_len equals the pixel count.
    always_comb begin
        hs_edge    = pxl_cen & HS & ~hs_last_q;
        cur_pxl    = {HB, blue, green, red};
        wr_bank    = hs_edge ? ~bank_q : bank_q;
        wr_sel     = hs_edge ? '0 : wr_addr_q;
        hs_last_d  = hs_last_q;
        synced_d   = synced_q;
        bank_d     = bank_q;
        en_lat_d   = en_lat_q;
        wr_addr_d  = wr_addr_q;
        line_len_d = line_len_q;
        hsw_d      = hsw_q;
        hsw_line_d = hsw_line_q;
        vb_line_d  = vb_line_q;
        vs_line_d  = vs_line_q;
        byp_d      = byp_q;
        if (pxl_cen) begin
            hs_last_d = HS;
            byp_d     = {red, green, blue, HB, VB, HS, VS};
            if (hs_edge) begin
                synced_d   = 1'b1;
                bank_d     = ~bank_q;
                en_lat_d   = en;
                // a line cut short by reset is not a valid line
                line_len_d = synced_q ? wr_addr_q : '0;
                wr_addr_d  = AW'(1);
                hsw_d      = 8'd1;
                hsw_line_d = hsw_q;
                // last pixel of the line just completed
                vb_line_d  = byp_q.vb;
                vs_line_d  = byp_q.vs;
            end else begin
                if (synced_q && wr_addr_q != ADDR_MAX) wr_addr_d = wr_addr_q + AW'(1);
                if (HS && hsw_q != 8'hFF) hsw_d = hsw_q + 8'd1;
            end
        end
    end

    // Read side: address wrap, then the 2-tick output pipeline
    always_comb begin
        hsw_eff   = (hsw_line_q > HSW_FLOOR) ? hsw_line_q : HSW_FLOOR;
        rd_addr_d = rd_addr_q;
        val1_d = val1_q; hs1_d = hs1_q; vb1_d = vb1_q; vs1_d = vs1_q;
        val2_d = val2_q; hs2_d = hs2_q; vb2_d = vb2_q; vs2_d = vs2_q;
        pix2_d = pix2_q;
        if (pxl2_cen) begin
            // an HS edge restarts the pair even if a wrap was due
            if (hs_edge || line_len_q == '0 || rd_addr_q == line_len_q - AW'(1))
                rd_addr_d = '0;
            else
                rd_addr_d = rd_addr_q + AW'(1);
            val1_d = (line_len_q != '0);
            hs1_d  = 32'(rd_addr_q) < 32'(hsw_eff);
            vb1_d  = vb_line_q;
            vs1_d  = vs_line_q;
            val2_d = val1_q;
            pix2_d = rd_pxl;
            hs2_d  = hs1_q;
            vb2_d  = vb1_q;
            vs2_d  = vs1_q;
        end
    end

    // Output select: idle until synced, then doubled or bypass
    always_comb begin
        out_vid = VID_IDLE;
        if (synced_q) begin
            if (!en_lat_q)
                out_vid = byp_q;
            else if (val2_q)
                out_vid = {pix2_q.r, pix2_q.g, pix2_q.b, pix2_q.hb, vb2_q, hs2_q, vs2_q};
        end
    end

    assign {dbl_red, dbl_green, dbl_blue, dbl_HB, dbl_VB, dbl_HS, dbl_VS} = out_vid;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_last_q  <= 1'b0;
            synced_q   <= 1'b0;
            bank_q     <= 1'b0;
            en_lat_q   <= 1'b0;
            wr_addr_q  <= '0;
            line_len_q <= '0;
            hsw_q      <= '0;
            hsw_line_q <= '0;
            vb_line_q  <= 1'b1;
            vs_line_q  <= 1'b0;
            byp_q      <= VID_IDLE;
            rd_addr_q  <= '0;
            val1_q <= 1'b0; hs1_q <= 1'b0; vb1_q <= 1'b1; vs1_q <= 1'b0;
            val2_q <= 1'b0; hs2_q <= 1'b0; vb2_q <= 1'b1; vs2_q <= 1'b0;
            pix2_q <= '0;
        end else begin
            hs_last_q  <= hs_last_d;
            synced_q   <= synced_d;
            bank_q     <= bank_d;
            en_lat_q   <= en_lat_d;
            wr_addr_q  <= wr_addr_d;
            line_len_q <= line_len_d;
            hsw_q      <= hsw_d;
            hsw_line_q <= hsw_line_d;
            vb_line_q  <= vb_line_d;
            vs_line_q  <= vs_line_d;
            byp_q      <= byp_d;
            rd_addr_q  <= rd_addr_d;
            val1_q <= val1_d; hs1_q <= hs1_d; vb1_q <= vb1_d; vs1_q <= vs1_d;
            val2_q <= val2_d; hs2_q <= hs2_d; vb2_q <= vb2_d; vs2_q <= vs2_d;
            pix2_q <= pix2_d;
        end
    end

endmodule

// File: tb/tb_jtpopeye_scandbl.sv
// Randomised bench for the scan doubler against a line-level reference model.
module tb_jtpopeye_scandbl;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
    } tv_t;

    localparam tv_t IDLE  = 12'b000_000_00_1_1_0_0;
    localparam int  LMAX  = 511;
    localparam int  NHIST = 16384;

    logic       clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0, pxl2_cen = 1'b0, en = 1'b0;
    logic [2:0] red = '0, green = '0;
    logic [1:0] blue = '0;
    logic       HB = 1'b0, VB = 1'b0, HS = 1'b0, VS = 1'b0;
    logic [2:0] dbl_red, dbl_green;
    logic [1:0] dbl_blue;
    logic       dbl_HB, dbl_VB, dbl_HS, dbl_VS;
    logic [11:0] dut_out;

    always #5 clk = ~clk;

    jtpopeye_scandbl dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .pxl2_cen(pxl2_cen), .en(en),
        .red(red), .green(green), .blue(blue),
        .HB(HB), .VB(VB), .HS(HS), .VS(VS),
        .dbl_red(dbl_red), .dbl_green(dbl_green), .dbl_blue(dbl_blue),
        .dbl_HB(dbl_HB), .dbl_VB(dbl_VB), .dbl_HS(dbl_HS), .dbl_VS(dbl_VS)
    );

    assign dut_out = {dbl_red, dbl_green, dbl_blue, dbl_HB, dbl_VB, dbl_HS, dbl_VS};

    int    n_chk = 0, n_fail = 0;
    int    ncnt  = 0;           // pxl_cen tick index; pxl2 tick index is 2*ncnt (+1)
    tv_t   in_arr [NHIST];
    int    edge_n[$];           // pxl_cen index of each HS rise since reset
    bit    edge_en[$];          // en value seen at that rise
    bit    prev_hs = 1'b0;
    string tag = "reset";

    task automatic chk(input string t, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (pixel tick %0d)", t, got, exp, ncnt);
        end
    endtask

    function automatic int last_edge(input int m);
        for (int i = edge_n.size() - 1; i >= 0; i--)
            if (2 * edge_n[i] <= m) return i;
        return -1;
    endfunction

    // Expected output visible just after pxl2 tick m
    function automatic tv_t exp_out(input int m);
        int  k, j, n0, n1, len, pos, w, hmin;
        tv_t p, q, r;
        k = last_edge(m);
        if (k < 0) return IDLE;
        if (!edge_en[k]) return in_arr[m / 2];
        // replay uses the line that ended at the latest edge two ticks back
        j = last_edge(m - 2);
        if (j < 1) return IDLE;
        n0  = edge_n[j-1];
        n1  = edge_n[j];
        len = (n1 - n0 > LMAX) ? LMAX : n1 - n0;
        pos = (m - 2 - 2 * n1) % len;
        p   = in_arr[n0 + pos];
        q   = in_arr[n1 - 1];
        w = 0;
        while (w < 255 && n0 + w < n1 && in_arr[n0 + w].hs) w++;
        hmin = (w > 4) ? w : 4;
        r = p;
        r.vb = q.vb;
        r.vs = q.vs;
        r.hs = (pos < hmin);
        return r;
    endfunction

    // One native pixel period: 4 clk, pxl2_cen on clk 0 and 2, pxl_cen on clk 0
    task automatic px(input tv_t p);
        if (ncnt >= NHIST) begin
            $display("FAIL history: got %0d pixel ticks, limit %0d", ncnt, NHIST);
            $fatal(1);
        end
        for (int c = 0; c < 4; c++) begin
            pxl_cen  = (c == 0);
            pxl2_cen = (c == 0) || (c == 2);
            if (c == 0) begin
                red = p.r; green = p.g; blue = p.b;
                HB = p.hb; VB = p.vb; HS = p.hs; VS = p.vs;
                in_arr[ncnt] = p;
                if (rst) begin
                    edge_n.delete(); edge_en.delete(); prev_hs = 1'b0;
                end else begin
                    if (p.hs && !prev_hs) begin
                        edge_n.push_back(ncnt);
                        edge_en.push_back(en);
                    end
                    prev_hs = p.hs;
                end
            end
            @(posedge clk); #1;
            if (pxl2_cen) chk(tag, dut_out, exp_out(2 * ncnt + ((c == 2) ? 1 : 0)));
        end
        ncnt++;
    endtask

    // One input line; HS high for the first hsw pixels
    task automatic line(input int P, input int hsw, input bit vb, input bit vs,
                        input bit ramp, input int en_at, input bit en_val,
                        input int rst_at, input int rst_len);
        tv_t p;
        for (int i = 0; i < P; i++) begin
            if (i == en_at) en = en_val;
            if (rst_at >= 0) rst = (i >= rst_at) && (i < rst_at + rst_len);
            if (ramp) begin
                {p.b, p.g, p.r} = 8'(i % 256);
                p.hb = (i >= P - 64);
            end else begin
                {p.b, p.g, p.r} = 8'($urandom);
                p.hb = 1'($urandom);
            end
            p.hs = (i < hsw);
            p.vb = vb;
            p.vs = vs;
            px(p);
        end
    endtask

    initial begin
        tv_t p;
        for (int i = 0; i < 3; i++) begin
            {p.r, p.g, p.b, p.hb, p.vb, p.vs} = 10'($urandom);
            p.hs = 1'b0;
            px(p);
        end
        rst = 1'b0;
        en  = 1'b1;

        tag = "dbl384";
        repeat (4) line(384, 32, 1'b0, 1'b0, 1'b1, -1, 1'b0, -1, 0);
        tag = "hs2";
        repeat (4) line(100, 2, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1, 0);
        tag = "long600";
        repeat (3) line(600, 8, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1, 0);
        tag = "vb";
        for (int l = 0; l < 245; l++)
            line(12, 3, (l >= 240), (l == 242), 1'b0, -1, 1'b0, -1, 0);
        tag = "en_toggle";
        for (int l = 0; l < 18; l++)
            line(64, 4, 1'b0, 1'b0, 1'b0, (l == 10) ? 30 : ((l == 14) ? 5 : -1),
                 (l == 14), -1, 0);
        tag = "rst_mid";
        line(200, 4, 1'b0, 1'b0, 1'b0, -1, 1'b0, 100, 4);
        repeat (3) line(200, 4, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtpopeye_scandbl.md
JTPOPEYE_SCANDBL -- requirements
Module: jtpopeye_scandbl

Interface
REQ-001 Parameter: AW, default 9, line-buffer address width (512 pixels per line max).
REQ-002 Parameter: HSW_MIN, default 4, minimum output HS width in pxl2_cen ticks.
REQ-003 Ports: one clock; reset is asynchronous and active-high (clk, rst).
REQ-004 clk  input  1  system clock, all logic on posedge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 pxl_cen  input  1  native pixel-rate clock enable.
REQ-007 pxl2_cen  input  1  double pixel-rate clock enable, coincident with every pxl_cen.
REQ-008 en  input  1  1 = scan-doubled output, 0 = bypass.
REQ-009 red, green  input  3 each  native colour from colour mixer.
REQ-010 blue  input  2  native colour from colour mixer.
REQ-011 HB, VB, HS, VS  input  1 each  native blanking/sync, active-high.
REQ-012 dbl_red, dbl_green  output  3 each  doubled colour.
REQ-013 dbl_blue  output  2  doubled colour.
REQ-014 dbl_HB, dbl_VB, dbl_HS, dbl_VS  output  1 each  doubled blanking/sync, active-high.

Function
REQ-015 Write side shall sample {HB,blue,green,red} (9 bits) on each pxl_cen into the write bank at wr_addr, then increment wr_addr.
REQ-016 Rising edge of HS (sampled on pxl_cen) shall: capture wr_addr into line_len, clear wr_addr to 0, toggle bank select, capture VB/VS into line-delayed registers.
REQ-017 wr_addr shall saturate at 2^AW-1; writes past that point shall overwrite the last location; line_len therefore saturates at 2^AW-1.
REQ-018 Read side shall read the non-write bank at rd_addr on each pxl2_cen; rd_addr increments and wraps to 0 when rd_addr == line_len-1, producing exactly two output lines per input line.
REQ-019 Input HS rising edge shall force rd_addr to 0 on the same pxl2_cen tick, overriding the wrap rule.
REQ-020 line_len == 0 (first line after reset) shall hold rd_addr at 0 and force dbl_HB = 1.
REQ-021 Read latency: colour/HB outputs shall be registered, valid 2 pxl2_cen ticks after rd_addr is presented.
REQ-022 HS width: count pxl_cen ticks of input HS high into hsw (saturating at 255); dbl_HS shall be high while rd_addr < max(hsw, HSW_MIN), aligned with the same 2-tick latency.
REQ-023 dbl_VB and dbl_VS shall equal input VB/VS delayed by one input line (values captured at REQ-016).
REQ-024 Bypass (en == 0): all dbl_* outputs shall equal the corresponding inputs registered on pxl_cen; line buffers keep writing.
REQ-025 Change of en shall take effect at the next input HS rising edge only.
REQ-026 Simultaneous wrap and HS edge: REQ-019 wins; no output line longer than line_len is emitted.

Reset
REQ-027 rst shall clear wr_addr, rd_addr, line_len, hsw, bank select, and en_latched to 0.
REQ-028 During and after reset, until the first valid line: all colour outputs = 0, dbl_HB = dbl_VB = 1, dbl_HS = dbl_VS = 0.
REQ-029 Reset asserted mid-line shall abort the line; the first output after release follows REQ-020.

Structure
REQ-030 Shared package jtpopeye_pkg shall hold AW, the 9-bit pixel-word layout {HB,B[1:0],G[2:0],R[2:0]}, and HSW_MIN.
REQ-031 Line storage shall be one sub-module jtpopeye_linebuf: two 2^AW x 9 banks, one write port (pxl_cen), one registered read port (pxl2_cen).
REQ-032 No other sub-modules; edge detectors and counters live in jtpopeye_scandbl.

Verification
REQ-033 Lines of 384 pixels, pixel = index mod 256 -> each line emitted twice, 384 pixels each, content identical, 2-tick latency.
REQ-034 Input HS high 32 pxl_cen ticks -> dbl_HS high 32 pxl2_cen ticks at start of each doubled line; HS high 2 ticks -> dbl_HS 4 ticks.
REQ-035 Line of 600 pixels (AW=9) -> line_len = 511, pixel 511 holds value of pixel 599, no address wrap error.
REQ-036 VB rises on line 240 -> dbl_VB rises at start of output line pair for input line 241.
REQ-037 en toggled 1->0 mid-line 10 -> doubled output until line 11 HS edge, then bypass with 1-pxl_cen latency.
REQ-038 rst pulsed at pixel 100 of a line -> outputs per REQ-028; first doubled line appears after second HS edge.
